fetch_sequencer: RTL

Program-counter sequencer that drives the registered-read instruction memory and presents fetched instructions to decode over a valid/ready handshake. It sits between the instruction memory (one-cycle synchronous read, word index = address/4) and the decode stage. It absorbs the memory's read latency, holds the output stable under back-pressure, applies branch/jump redirects, and traps illegal fetch addresses.

---
 rtl/fetch_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer between a one-cycle registered instruction memory and decode.
// Absorbs read latency, holds output under back-pressure, applies redirects, traps bad fetches.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [1:0]  ST_BOOT   = 2'd0;
  localparam logic [1:0]  ST_RUN    = 2'd1;
  localparam logic [1:0]  ST_FAULT  = 2'd2;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS * 4);

  logic [1:0]  state_q, state_d;
  logic [31:0] cur_pc_q, cur_pc_d;
  logic        cur_valid_q, cur_valid_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] next_addr;
  logic        check_en;
  logic        illegal;

  // A redirect kills the word on the output this cycle; reset hides any stale RUN state.
  assign out_valid = cur_valid_q && (state_q == ST_RUN) && !redirect_valid && !reset;
  assign out_pc    = cur_pc_q;
  assign out_instr = imem_instr;
  assign fault     = (state_q == ST_FAULT);
  assign fault_pc  = fault_pc_q;
  assign imem_addr = reset ? RESET_PC : next_addr;
  assign illegal   = (next_addr[1:0] != 2'b00) || (next_addr >= MEM_LIMIT);

  always_comb begin
    state_d     = state_q;
    cur_pc_d    = cur_pc_q;
    cur_valid_d = cur_valid_q;
    fault_pc_d  = fault_pc_q;
    next_addr   = cur_pc_q;
    check_en    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        next_addr = RESET_PC;
        check_en  = 1'b1;
      end
      ST_RUN: begin
        check_en = 1'b1;
        if (redirect_valid) begin
          next_addr = redirect_pc;
        end else if (out_valid && out_ready) begin
          next_addr = cur_pc_q + 32'd4;
        end else begin
          next_addr = cur_pc_q;
        end
      end
      ST_FAULT: begin
        next_addr = cur_pc_q;
      end
      default: begin
        next_addr   = RESET_PC;
        state_d     = ST_BOOT;
        cur_valid_d = 1'b0;
      end
    endcase
    // Stalling re-presents cur_pc, so the memory returns the same word and the output holds.
    if (check_en) begin
      if (illegal) begin
        state_d     = ST_FAULT;
        fault_pc_d  = next_addr;
        cur_valid_d = 1'b0;
      end else begin
        state_d     = ST_RUN;
        cur_pc_d    = next_addr;
        cur_valid_d = 1'b1;
      end
    end else begin
      cur_pc_d = cur_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BOOT;
      cur_pc_q    <= RESET_PC;
      cur_valid_q <= 1'b0;
      fault_pc_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cur_pc_q    <= cur_pc_d;
      cur_valid_q <= cur_valid_d;
      fault_pc_q  <= fault_pc_d;
    end
  end

endmodule
